lane_gather: RTL and testbench

Stream-to-vector deserializer that feeds the `adder_tree` reduction datapath. It accepts one K-bit word per beat on a valid/ready stream and packs consecutive words into an N-lane vector. It presents the vector on a valid/ready output and holds one complete vector in a pending stage while the output is stalled. A short vector, closed early by `s_last`, has its unused lanes zero-filled, so the downstream sum is unaffected by them.

---
 rtl/lane_gather.sv | 98 +++++++++
 tb/tb_lane_gather.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_gather.sv
// Stream-to-vector deserializer: packs K-bit beats into an N-lane vector, zero-filling
// lanes past an early s_last, with one pending slot behind the output register.
module lane_gather #(
  parameter int unsigned N = 12,
  parameter int unsigned K = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [K-1:0]               s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [K-1:0]               m_data [0:N-1],
  output logic [$clog2(N+1)-1:0]     m_count
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(N+1);

  logic [K-1:0]  fill_q [0:N-1];
  logic [K-1:0]  pend_q [0:N-1];
  logic [IW-1:0] fill_idx_q;
  logic [CW-1:0] pend_cnt_q;
  logic          pending_q;

  logic [K-1:0]  vec [0:N-1];
  logic [CW-1:0] vec_cnt;
  logic          beat;
  logic          complete;
  logic          out_free;
  logic          xfer;

  always_comb begin
    s_ready  = !pending_q;
    beat     = s_valid && s_ready;
    complete = beat && ((fill_idx_q == IW'(N - 1)) || s_last);
    out_free = !m_valid || m_ready;
    xfer     = m_valid && m_ready;
    vec_cnt  = CW'(fill_idx_q) + CW'(1);
    // Lanes above the closing index are forced to zero so no stale word can leak out.
    for (int unsigned i = 0; i < N; i++) begin
      if (IW'(i) == fill_idx_q) begin
        vec[i] = s_data;
      end else if (IW'(i) < fill_idx_q) begin
        vec[i] = fill_q[i];
      end else begin
        vec[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_idx_q <= '0;
      pend_cnt_q <= '0;
      pending_q  <= 1'b0;
      m_valid    <= 1'b0;
      m_count    <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        fill_q[i] <= '0;
        pend_q[i] <= '0;
        m_data[i] <= '0;
      end
    end else begin
      // Fill stage
      if (complete) begin
        fill_idx_q <= '0;
        for (int unsigned i = 0; i < N; i++) begin
          fill_q[i] <= '0;
        end
      end else if (beat) begin
        fill_q[fill_idx_q] <= s_data;
        fill_idx_q         <= fill_idx_q + IW'(1);
      end

      // Output register and pending slot; completion cannot coincide with a pending
      // drain because s_ready is low whenever pending is set.
      if (xfer && pending_q) begin
        m_data    <= pend_q;
        m_count   <= pend_cnt_q;
        pending_q <= 1'b0;
      end else if (complete && out_free) begin
        m_data  <= vec;
        m_count <= vec_cnt;
        m_valid <= 1'b1;
      end else if (complete) begin
        pend_q     <= vec;
        pend_cnt_q <= vec_cnt;
        pending_q  <= 1'b1;
      end else if (xfer) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lane_gather.sv
// Scoreboard bench for lane_gather: a queue-based reference model predicts vectors,
// a negedge monitor pops and compares on every output transfer.
module tb_lane_gather;

  localparam int unsigned N  = 12;
  localparam int unsigned K  = 15;
  localparam int unsigned CW = $clog2(N+1);

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [K-1:0]  s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [K-1:0]  m_data [0:N-1];
  logic [CW-1:0] m_count;

  lane_gather #(.N(N), .K(K)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;

  // Reference model: words of the vector being gathered, and predicted outputs.
  logic [K-1:0]     cur_q [$];
  logic [N*K-1:0]   exp_d [$];
  logic [CW-1:0]    exp_c [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*K-1:0] flat();
    logic [N*K-1:0] v;
    for (int i = 0; i < N; i++) v[i*K +: K] = m_data[i];
    return v;
  endfunction

  task automatic model_accept(input logic [K-1:0] d, input bit last);
    logic [N*K-1:0] v;
    cur_q.push_back(d);
    if (last || cur_q.size() == N) begin
      v = '0;
      foreach (cur_q[i]) v[i*K +: K] = cur_q[i];
      exp_d.push_back(v);
      exp_c.push_back(CW'(cur_q.size()));
      cur_q.delete();
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [K-1:0] d, input bit last);
    int tries = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        model_accept(d, last);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      tries++;
      if (tries > 50) begin
        check("s_ready_timeout", 64'(s_ready), 64'd1);
        s_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: stall stability and scoreboard comparison on every transfer.
  logic [N*K-1:0] held;
  logic [CW-1:0]  held_cnt;
  bit             held_v = 0;

  always @(negedge clk) begin
    logic [N*K-1:0] cur;
    logic [N*K-1:0] ed;
    logic [CW-1:0]  ec;
    if (!rst_n) begin
      held_v = 0;
    end else begin
      cur = flat();
      if (held_v) begin
        checks++;
        if (!m_valid || cur !== held || m_count !== held_cnt) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b cnt=%0d data=%0h required v=1 cnt=%0d data=%0h",
                   m_valid, m_count, cur, held_cnt, held);
        end
      end
      if (m_valid && m_ready) begin
        xfers++;
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vector: got cnt=%0d data=%0h required none", m_count, cur);
        end else begin
          ed = exp_d.pop_front();
          ec = exp_c.pop_front();
          if (cur !== ed || m_count !== ec) begin
            errors++;
            $display("FAIL vector: got cnt=%0d data=%0h required cnt=%0d data=%0h",
                     m_count, cur, ec, ed);
          end
        end
      end
      held_v   = m_valid && !m_ready;
      held     = cur;
      held_cnt = m_count;
    end
  end

  bit done;
  int base;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("reset_m_valid", 64'(m_valid), 64'd0);
    check("reset_m_count", 64'(m_count), 64'd0);
    check("reset_m_data_zero", 64'(flat() == '0), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("reset_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Full vector 1..12, one-cycle latency, single valid cycle
    m_ready = 1'b1;
    base = xfers;
    for (int i = 1; i <= 12; i++) send(K'(i), 1'b0);
    @(negedge clk);
    check("full_latency_valid", 64'(m_valid), 64'd1);
    @(negedge clk);
    check("full_valid_drop", 64'(m_valid), 64'd0);
    check("full_one_vector", 64'(xfers - base), 64'd1);
    @(posedge clk);
    #1;

    // Short vector then full vector: no residue
    send(K'(16'h7FFF), 1'b0);
    for (int i = 2; i <= 5; i++) send(K'(i), i == 5);
    for (int i = 0; i < 12; i++) send(K'(40 + i), 1'b0);
    idle(3);

    // Backpressure: two full vectors stalled, third beat held off
    m_ready = 1'b0;
    for (int i = 13 - 12; i <= 24; i++) send(K'(i), 1'b0);
    s_valid = 1'b1;
    s_data  = K'(25);
    s_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_s_ready_low", 64'(s_ready), 64'd0);
      check("bp_m_valid_high", 64'(m_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    base = xfers;
    @(negedge clk);
    @(negedge clk);
    check("bp_s_ready_back", 64'(s_ready), 64'd1);
    check("bp_b_valid", 64'(m_valid), 64'd1);
    @(negedge clk);
    check("bp_drained", 64'(m_valid), 64'd0);
    check("bp_two_vectors", 64'(xfers - base), 64'd2);
    @(posedge clk);
    #1;

    // Same-cycle drain and complete
    m_ready = 1'b0;
    send(K'(201), 1'b0);
    send(K'(202), 1'b0);
    send(K'(203), 1'b1);
    send(K'(204), 1'b0);
    send(K'(205), 1'b0);
    m_ready = 1'b1;
    base = xfers;
    send(K'(206), 1'b1);
    @(negedge clk);
    check("same_cycle_valid_kept", 64'(m_valid), 64'd1);
    @(negedge clk);
    check("same_cycle_valid_drop", 64'(m_valid), 64'd0);
    check("same_cycle_two_vectors", 64'(xfers - base), 64'd2);
    @(posedge clk);
    #1;

    // Reset mid-vector
    for (int i = 0; i < 7; i++) send(K'(300 + i), 1'b0);
    #2 rst_n = 1'b0;
    cur_q.delete();
    @(negedge clk);
    check("midreset_m_valid", 64'(m_valid), 64'd0);
    check("midreset_m_count", 64'(m_count), 64'd0);
    check("midreset_m_data_zero", 64'(flat() == '0), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 100; i <= 111; i++) send(K'(i), 1'b0);
    idle(3);

    // Single-beat vectors
    base = xfers;
    for (int i = 0; i < 6; i++) send(K'($urandom), 1'b1);
    idle(3);
    check("single_beat_six_vectors", 64'(xfers - base), 64'd6);

    // Randomized traffic with random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(K'($urandom), $urandom_range(0, 4) == 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    m_ready = 1'b1;
    for (int i = 0; i < 40 && exp_d.size() > 0; i++) @(negedge clk);
    check("drain_scoreboard_empty", 64'(exp_d.size()), 64'd0);
    idle(2);
    check("final_m_valid", 64'(m_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
